// File: rtl/i2s_receiver.sv
`default_nettype none
// ============================================================================
// Module      : i2s_receiver
// Description : I2S slave receiver. Synchronises bclk/lrclk/sdata into clk,
//               deserialises left/right words and emits one stereo frame per
//               LR period on a valid/ready interface.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_receiver #(
  parameter int DATA_WIDTH = 24,
  parameter int SLOT_WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i2s_bclk,
  input  logic        i2s_lrclk,
  input  logic        i2s_sdata,
  output logic [63:0] frame_data,
  output logic        frame_valid,
  input  logic        frame_ready,
  output logic        overrun,
  output logic        frame_err
);

  localparam int c_CNT_W = $clog2(DATA_WIDTH + 1);
  localparam int c_PAD_W = 32 - DATA_WIDTH;
  localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DATA_WIDTH);
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } state_t;

  if (DATA_WIDTH < 2 || DATA_WIDTH > 31 || SLOT_WIDTH <= DATA_WIDTH) begin : g_param_check
    $error("i2s_receiver: unsupported DATA_WIDTH/SLOT_WIDTH combination");
  end

  logic [2:0]            r_bclk_sync;
  logic [1:0]            r_lr_sync;
  logic [1:0]            r_sd_sync;
  logic                  r_lr_prev;
  logic [c_CNT_W-1:0]    r_bit_cnt;
  logic [DATA_WIDTH-2:0] r_shreg;
  logic [DATA_WIDTH-1:0] r_left_hold;
  logic [63:0]           r_frame_data;
  logic                  r_frame_valid;
  logic                  r_overrun;
  logic                  r_frame_err;
  state_t                r_state;
  state_t                w_state_nxt;

  logic                  w_bclk_rise;
  logic                  w_lr;
  logic                  w_sd;
  logic                  w_lr_change;
  logic [DATA_WIDTH-1:0] w_word;
  logic                  w_word_done;
  logic                  w_frame_done;
  logic                  w_slot_err;

  assign w_bclk_rise = r_bclk_sync[1] & ~r_bclk_sync[2];
  assign w_lr        = r_lr_sync[1];
  assign w_sd        = r_sd_sync[1];
  assign w_lr_change = w_lr != r_lr_prev;
  // Full word as it stands once the current bit has been shifted in.
  assign w_word      = {r_shreg, w_sd};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bclk_sync <= '0;
      r_lr_sync   <= '0;
      r_sd_sync   <= '0;
    end else begin
      r_bclk_sync <= {r_bclk_sync[1:0], i2s_bclk};
      r_lr_sync   <= {r_lr_sync[0], i2s_lrclk};
      r_sd_sync   <= {r_sd_sync[0], i2s_sdata};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_SYNC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_word_done  = 1'b0;
    w_frame_done = 1'b0;
    w_slot_err   = 1'b0;
    if (w_bclk_rise) begin
      if (w_lr_change) begin
        // An LR edge closes the previous slot; its bit belongs to that slot.
        case (r_state)
          ST_SYNC: begin
            if (!w_lr) begin
              w_state_nxt = ST_LEFT;
            end
          end
          ST_LEFT: begin
            if (r_bit_cnt == c_FULL) begin
              w_state_nxt = ST_RIGHT;
            end else begin
              w_slot_err  = 1'b1;
              w_state_nxt = ST_SYNC;
            end
          end
          ST_RIGHT: begin
            if (r_bit_cnt == c_FULL) begin
              w_state_nxt = ST_LEFT;
            end else begin
              w_slot_err  = 1'b1;
              w_state_nxt = ST_SYNC;
            end
          end
          default: w_state_nxt = ST_SYNC;
        endcase
      end else if (r_bit_cnt == c_LAST) begin
        w_word_done  = 1'b1;
        w_frame_done = (r_state == ST_RIGHT);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lr_prev   <= 1'b0;
      r_bit_cnt   <= '0;
      r_shreg     <= '0;
      r_left_hold <= '0;
    end else if (w_bclk_rise) begin
      r_lr_prev <= w_lr;
      if (w_lr_change) begin
        r_bit_cnt <= '0;
      end else if (r_bit_cnt < c_FULL) begin
        r_shreg   <= w_word[DATA_WIDTH-2:0];
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
      if (w_word_done && r_state == ST_LEFT) begin
        r_left_hold <= w_word;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frame_data  <= '0;
      r_frame_valid <= 1'b0;
      r_overrun     <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_overrun   <= 1'b0;
      r_frame_err <= w_slot_err;
      if (w_frame_done) begin
        // A consumer accepting this cycle frees the slot for the new frame.
        if (!r_frame_valid || frame_ready) begin
          r_frame_data  <= {{c_PAD_W{1'b0}}, r_left_hold, {c_PAD_W{1'b0}}, w_word};
          r_frame_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_frame_valid && frame_ready) begin
        r_frame_valid <= 1'b0;
      end
    end
  end

  assign frame_data  = r_frame_data;
  assign frame_valid = r_frame_valid;
  assign overrun     = r_overrun;
  assign frame_err   = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_i2s_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2s_receiver
// Description : Self-checking bench for i2s_receiver with a slot-level I2S
//               stream generator and an expected-frame reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_receiver;

  logic        clk = 1'b0;
  logic        reset;
  logic        i2s_bclk;
  logic        i2s_lrclk;
  logic        i2s_sdata;
  logic [63:0] frame_data;
  logic        frame_valid;
  logic        frame_ready;
  logic        overrun;
  logic        frame_err;

  always #5 clk = ~clk;

  i2s_receiver #(
    .DATA_WIDTH(24),
    .SLOT_WIDTH(32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i2s_bclk   (i2s_bclk),
    .i2s_lrclk  (i2s_lrclk),
    .i2s_sdata  (i2s_sdata),
    .frame_data (frame_data),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .overrun    (overrun),
    .frame_err  (frame_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Stream description: one entry per bclk period, lr and the slot bit
  // before the one-period I2S delay is applied.
  bit   q_lr[$];
  bit   q_bit[$];
  int   done_idx[$];
  bit   last_bit = 1'b0;
  time  done_t = 0;

  logic [63:0] got_q[$];
  int          n_overrun = 0;
  int          n_err = 0;
  time         valid_rise_t = 0;
  logic        prev_valid = 1'b0;

  always @(negedge clk) begin
    if (frame_valid === 1'b1 && frame_ready === 1'b1) got_q.push_back(frame_data);
    if (overrun === 1'b1) n_overrun++;
    if (frame_err === 1'b1) n_err++;
    if (frame_valid === 1'b1 && prev_valid !== 1'b1) valid_rise_t = $time - 5;
    prev_valid = frame_valid;
  end

  function automatic logic [63:0] mk(input logic [23:0] l, input logic [23:0] r);
    return {8'h00, l, 8'h00, r};
  endfunction

  task automatic add_slot(input bit lr, input logic [23:0] w, input int nbits);
    if (lr && nbits > 24) done_idx.push_back(q_lr.size() + 24);
    for (int i = 0; i < nbits; i++) begin
      q_lr.push_back(lr);
      q_bit.push_back(i < 24 ? w[23-i] : 1'($urandom));
    end
  endtask

  task automatic add_frame(input logic [23:0] l, input logic [23:0] r);
    add_slot(1'b0, l, 32);
    add_slot(1'b1, r, 32);
  endtask

  // Data changes on bclk fall, one bclk period behind its slot (I2S delay).
  task automatic play();
    for (int n = 0; n < q_lr.size(); n++) begin
      @(posedge clk); #3;
      i2s_bclk  = 1'b0;
      i2s_lrclk = q_lr[n];
      i2s_sdata = (n == 0) ? last_bit : q_bit[n-1];
      repeat (8) @(posedge clk);
      #3;
      i2s_bclk = 1'b1;
      if (done_idx.size() > 0 && done_idx[0] == n) begin
        done_t = $time;
        void'(done_idx.pop_front());
      end
      repeat (7) @(posedge clk);
    end
    if (q_bit.size() > 0) last_bit = q_bit[q_bit.size()-1];
    q_lr.delete();
    q_bit.delete();
    done_idx.delete();
    repeat (6) @(posedge clk);
  endtask

  task automatic set_ready(input bit v);
    @(posedge clk); #1;
    frame_ready = v;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2;
    reset     = 1'b1;
    i2s_bclk  = 1'b0;
    i2s_lrclk = 1'b0;
    i2s_sdata = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic expect_frames(input string name, input logic [63:0] exp[$]);
    n_checks++;
    if (got_q.size() !== exp.size()) begin
      n_errors++;
      $display("FAIL %s_count: got %0d frames, expected %0d", name, got_q.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        n_checks++;
        if (got_q[i] !== exp[i]) begin
          n_errors++;
          $display("FAIL %s_data[%0d]: got %h expected %h", name, i, got_q[i], exp[i]);
        end
      end
    end
    got_q.delete();
  endtask

  task automatic test_reset();
    logic [23:0] l, r;
    logic [63:0] exp[$];
    reset       = 1'b1;
    frame_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #3;
      i2s_bclk  = 1'($urandom);
      i2s_lrclk = 1'($urandom);
      i2s_sdata = 1'($urandom);
    end
    @(negedge clk);
    n_checks++;
    if (frame_data !== 64'h0) begin n_errors++; $display("FAIL reset_data: got %h expected 0", frame_data); end
    n_checks++;
    if (frame_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b expected 0", frame_valid); end
    n_checks++;
    if (overrun !== 1'b0) begin n_errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    n_checks++;
    if (frame_err !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %b expected 0", frame_err); end
    i2s_bclk  = 1'b0;
    i2s_lrclk = 1'b0;
    i2s_sdata = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    got_q.delete();
    n_err = 0;
    n_overrun = 0;
    add_slot(1'b1, 24'($urandom), 32);
    play();
    n_checks++;
    if (got_q.size() != 0 || frame_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_no_partial: got %0d frames valid=%b expected 0", got_q.size(), frame_valid);
    end
    l = 24'($urandom);
    r = 24'($urandom);
    add_frame(l, r);
    play();
    exp.push_back(mk(l, r));
    expect_frames("reset_first", exp);
  endtask

  task automatic test_basic();
    logic [63:0] exp[$];
    logic [23:0] l, r;
    int ov0, er0;
    ov0 = n_overrun;
    er0 = n_err;
    add_frame(24'hABCDEF, 24'h123456);
    play();
    exp.push_back(64'h00ABCDEF_00123456);
    expect_frames("basic", exp);
    n_checks++;
    if (valid_rise_t < done_t + 20 || valid_rise_t > done_t + 40) begin
      n_errors++;
      $display("FAIL basic_latency: got %0t after bclk edge, expected 20..40 ns", valid_rise_t - done_t);
    end
    exp.delete();
    for (int i = 0; i < 3; i++) begin
      l = 24'($urandom);
      r = 24'($urandom);
      add_frame(l, r);
      exp.push_back(mk(l, r));
    end
    play();
    expect_frames("basic_rand", exp);
    n_checks++;
    if (n_overrun != ov0 || n_err != er0) begin
      n_errors++;
      $display("FAIL basic_flags: got overrun %0d err %0d, expected 0 0", n_overrun - ov0, n_err - er0);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] exp[$];
    int ov0;
    ov0 = n_overrun;
    set_ready(1'b0);
    add_frame(24'h000001, 24'h000002);
    play();
    n_checks++;
    if (frame_valid !== 1'b1 || frame_data !== 64'h00000001_00000002) begin
      n_errors++;
      $display("FAIL bp_first: got valid %b data %h expected 1 00000001_00000002", frame_valid, frame_data);
    end
    add_frame(24'h000003, 24'h000004);
    play();
    n_checks++;
    if (frame_data !== 64'h00000001_00000002) begin
      n_errors++;
      $display("FAIL bp_hold: got %h expected 00000001_00000002", frame_data);
    end
    n_checks++;
    if (n_overrun - ov0 != 1) begin
      n_errors++;
      $display("FAIL bp_overrun: got %0d pulse cycles expected 1", n_overrun - ov0);
    end
    set_ready(1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (frame_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL bp_drain_valid: got %b expected 0", frame_valid);
    end
    exp.push_back(64'h00000001_00000002);
    expect_frames("bp_drain", exp);
    exp.delete();
    add_frame(24'h000005, 24'h000006);
    play();
    exp.push_back(64'h00000005_00000006);
    expect_frames("bp_next", exp);
  endtask

  task automatic test_midstream();
    logic [63:0] exp[$];
    logic [23:0] l, r;
    int er0;
    pulse_reset();
    er0 = n_err;
    add_slot(1'b1, 24'($urandom), 22);
    play();
    n_checks++;
    if (got_q.size() != 0 || n_err != er0) begin
      n_errors++;
      $display("FAIL mid_quiet: got %0d frames %0d errs expected 0 0", got_q.size(), n_err - er0);
    end
    l = 24'($urandom);
    r = 24'($urandom);
    add_frame(l, r);
    play();
    exp.push_back(mk(l, r));
    expect_frames("mid_first", exp);
    n_checks++;
    if (n_err != er0) begin n_errors++; $display("FAIL mid_err: got %0d expected 0", n_err - er0); end
  endtask

  task automatic test_short_slot();
    logic [63:0] exp[$];
    int er0;
    er0 = n_err;
    add_slot(1'b0, 24'($urandom), 10);
    add_slot(1'b1, 24'($urandom), 32);
    play();
    n_checks++;
    if (n_err - er0 != 1) begin
      n_errors++;
      $display("FAIL short_err: got %0d pulse cycles expected 1", n_err - er0);
    end
    n_checks++;
    if (got_q.size() != 0) begin
      n_errors++;
      $display("FAIL short_noframe: got %0d frames expected 0", got_q.size());
    end
    add_frame(24'h7FFFFF, 24'h800000);
    play();
    exp.push_back(64'h007FFFFF_00800000);
    expect_frames("short_next", exp);
  endtask

  task automatic test_async_reset();
    logic [63:0] exp[$];
    logic [23:0] l, r;
    set_ready(1'b0);
    add_frame(24'($urandom), 24'($urandom));
    play();
    n_checks++;
    if (frame_valid !== 1'b1) begin n_errors++; $display("FAIL ar_valid_before: got %b expected 1", frame_valid); end
    add_slot(1'b0, 24'($urandom), 12);
    play();
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (frame_valid !== 1'b0 || frame_data !== 64'h0) begin
      n_errors++;
      $display("FAIL ar_async_clear: got valid %b data %h expected 0 0", frame_valid, frame_data);
    end
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    set_ready(1'b1);
    add_slot(1'b0, 24'($urandom), 20);
    add_slot(1'b1, 24'($urandom), 32);
    l = 24'($urandom);
    r = 24'($urandom);
    add_frame(l, r);
    play();
    exp.push_back(mk(l, r));
    expect_frames("ar_next", exp);
  endtask

  initial begin
    reset       = 1'b1;
    frame_ready = 1'b1;
    i2s_bclk    = 1'b0;
    i2s_lrclk   = 1'b0;
    i2s_sdata   = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_midstream();
    test_short_slot();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not complete within 1 ms");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
